// File: rtl/wb_ram.sv
// -----------------------------------------------------------------------------
// wb_ram : Wishbone slave RAM with byte-select writes and fixed wait states.
//
// The upstream adapter pulses wb_stb for a single cycle and holds wb_cyc until
// it sees wb_ack, so the whole request is captured on the strobe and completed
// later while wb_cyc remains asserted.
//
// Ports
//   clock     : rising-edge clock
//   reset     : synchronous, active-low reset
//   wb_adr    : byte address (low byte-offset bits and upper bits ignored)
//   wb_datwr  : write data
//   wb_datrd  : read data, valid while wb_ack=1, held until the next read
//   wb_we     : 1=write, 0=read
//   wb_stb    : request strobe (may be a one-cycle pulse)
//   wb_cyc    : cycle active, held until ack
//   wb_sel    : byte enables for writes
//   wb_ack    : one-cycle completion pulse
//   busy      : a request is in flight (state != IDLE)
//   overrun   : sticky, a strobe arrived while busy
// -----------------------------------------------------------------------------
module wb_ram #(
   parameter int addr_width   = 32,
   parameter int data_width   = 32,
   parameter int strobe_width = data_width / 8,
   parameter int depth_log2   = 10,
   parameter int wait_states  = 0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [addr_width-1:0]   wb_adr,
   input  logic [data_width-1:0]   wb_datwr,
   output logic [data_width-1:0]   wb_datrd,
   input  logic                    wb_we,
   input  logic                    wb_stb,
   input  logic                    wb_cyc,
   input  logic [strobe_width-1:0] wb_sel,
   output logic                    wb_ack,
   output logic                    busy,
   output logic                    overrun
);

   localparam int off_bits = (strobe_width > 1) ? $clog2(strobe_width) : 0;
   localparam int depth    = 1 << depth_log2;
   localparam logic [3:0] wait_init = (wait_states == 0) ? 4'd0 : 4'(wait_states - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;

   logic [1:0]              state;
   logic [3:0]              wait_cnt;

   // Latched request
   logic [depth_log2-1:0]   idx_q;
   logic                    we_q;
   logic [data_width-1:0]   dat_q;
   logic [strobe_width-1:0] sel_q;

   logic [data_width-1:0]   mem [0:depth-1];

   // Request actually used at the commit edge: straight from the bus when
   // committing out of IDLE (zero wait states), otherwise the latched copy.
   logic                    capture;
   logic                    commit;
   logic [depth_log2-1:0]   idx_c;
   logic                    we_c;
   logic [data_width-1:0]   dat_c;
   logic [strobe_width-1:0] sel_c;

   // Address bits outside the word index are ignored by design (aliasing);
   // folded here so they count as consumed.
   logic unused_adr;
   assign unused_adr = ^wb_adr;

   assign capture = (state == ST_IDLE) && wb_cyc && wb_stb;
   assign busy    = (state != ST_IDLE);
   assign wb_ack  = (state == ST_ACK);

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can
      // leave it unassigned and infer a latch.
      idx_c  = idx_q;
      we_c   = we_q;
      dat_c  = dat_q;
      sel_c  = sel_q;
      commit = 1'b0;
      if (state == ST_IDLE) begin
         idx_c  = wb_adr[off_bits +: depth_log2];
         we_c   = wb_we;
         dat_c  = wb_datwr;
         sel_c  = wb_sel;
         commit = capture && (wait_states == 0);
      end else if (state == ST_WAIT) begin
         // Entering ACK also requires wb_cyc still high; otherwise it aborts.
         commit = wb_cyc && (wait_cnt == 4'd0);
      end
   end

   // Control path with synchronous reset.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register sees pre-edge values regardless of statement order.
      if (!reset) begin
         state    <= ST_IDLE;
         wait_cnt <= 4'd0;
         wb_datrd <= '0;
         overrun  <= 1'b0;
      end else begin
         if (commit && !we_c)
            wb_datrd <= mem[idx_c];
         if (wb_cyc && wb_stb && (state != ST_IDLE))
            overrun <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (capture) begin
                  if (wait_states == 0) begin
                     state <= ST_ACK;
                  end else begin
                     state    <= ST_WAIT;
                     wait_cnt <= wait_init;
                  end
               end
            end
            ST_WAIT: begin
               if (!wb_cyc)
                  state <= ST_IDLE;
               else if (wait_cnt == 4'd0)
                  state <= ST_ACK;
               else
                  wait_cnt <= wait_cnt - 4'd1;
            end
            ST_ACK:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Datapath: request latch and storage array.
   always_ff @(posedge clock) begin
      // NOTE: the memory and request latch carry no reset; only control state
      // is reset, and a write is suppressed while reset is asserted.
      if (capture) begin
         idx_q <= wb_adr[off_bits +: depth_log2];
         we_q  <= wb_we;
         dat_q <= wb_datwr;
         sel_q <= wb_sel;
      end
      if (commit && we_c && reset) begin
         for (int i = 0; i < strobe_width; i++) begin
            if (sel_c[i])
               mem[idx_c][8*i +: 8] <= dat_c[8*i +: 8];
         end
      end
   end

endmodule
